lockup_free_mshr: RTL and testbench

LOCKUP_FREE_MSHR -- requirements
Module: lockup_free_mshr

---
 rtl/lockup_free_mshr.sv | 178 +++++++++++++++++
 tb/tb_lockup_free_mshr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockup_free_mshr.sv
// Lockup-free MSHR: unified load/store miss pool with store-to-load line
// ordering and a single outstanding repair at a time.
module lockup_free_mshr #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ROB_ENTRIES = 32,
   parameter int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES),
   parameter int unsigned LINE_OFF_W  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         ld_alloc_en_i,
   input  logic [ADDR_W-1:0]            ld_alloc_addr_i,
   input  logic [ROB_IDX_W-1:0]         ld_alloc_rob_idx_i,
   input  logic                         st_alloc_en_i,
   input  logic [ADDR_W-1:0]            st_alloc_addr_i,
   input  logic [DATA_W-1:0]            st_alloc_data_i,
   output logic                         ld_full_o,
   output logic                         st_full_o,
   output logic [$clog2(NUM_ENTRIES):0] count_o,
   output logic                         repair_req_o,
   input  logic                         repair_ack_i,
   output logic [ADDR_W-1:0]            repair_req_addr_o,
   output logic [DATA_W-1:0]            repair_req_data_o,
   output logic [ROB_IDX_W-1:0]         repair_req_rob_idx_o,
   output logic                         repair_is_store_o,
   input  logic                         repair_complete_i,
   output logic                         repair_squashed_o
);
   localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
   localparam int unsigned CNT_W = IDX_W + 1;

   typedef enum logic [1:0] {FREE, WAIT, ISSUED} state_e;

   state_e                 state_q  [NUM_ENTRIES];
   logic [ADDR_W-1:0]      addr_q   [NUM_ENTRIES];
   logic [DATA_W-1:0]      data_q   [NUM_ENTRIES];
   logic [ROB_IDX_W-1:0]   rob_q    [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] dep_q    [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] is_store_q, squashed_q;
   logic [IDX_W-1:0]       rr_ptr_q, hold_idx_q;
   logic                   hold_q;

   logic [NUM_ENTRIES-1:0] free_v, elig_v, issued_v, ld_dep;
   logic [CNT_W-1:0]       num_free;
   logic [IDX_W-1:0]       ld_idx, st_idx, rr_idx, rr_probe, sel_idx, iss_idx;
   logic                   ld_found, st_found, rr_found, any_issued;
   logic                   ld_do, st_do, ack_do, cmpl_do;

   always_comb begin
      free_v   = '0;
      elig_v   = '0;
      issued_v = '0;
      num_free = '0;
      iss_idx  = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         free_v[i]   = (state_q[i] == FREE);
         elig_v[i]   = (state_q[i] == WAIT) && (dep_q[i] == '0);
         issued_v[i] = (state_q[i] == ISSUED);
         num_free    = num_free + CNT_W'(free_v[i]);
         if (issued_v[i]) iss_idx = IDX_W'(i);
      end
   end

   // The load claims the lowest free slot; the store skips it only when the load really allocates.
   always_comb begin
      ld_idx   = '0;
      ld_found = 1'b0;
      st_idx   = '0;
      st_found = 1'b0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (free_v[i] && !ld_found) begin
            ld_idx   = IDX_W'(i);
            ld_found = 1'b1;
         end
      end
      ld_do = ld_alloc_en_i && !flush_i && ld_found;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (free_v[i] && !st_found && !(ld_do && ld_idx == IDX_W'(i))) begin
            st_idx   = IDX_W'(i);
            st_found = 1'b1;
         end
      end
      st_do = st_alloc_en_i && st_found;
   end

   assign ld_full_o = (num_free == '0);
   assign st_full_o = ld_full_o || (num_free == CNT_W'(1) && ld_alloc_en_i && !flush_i);
   assign count_o   = CNT_W'(NUM_ENTRIES) - num_free;

   always_comb begin
      rr_idx   = '0;
      rr_found = 1'b0;
      rr_probe = '0;
      for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
         rr_probe = rr_ptr_q + IDX_W'(k);
         if (!rr_found && elig_v[rr_probe]) begin
            rr_idx   = rr_probe;
            rr_found = 1'b1;
         end
      end
   end

   assign any_issued           = |issued_v;
   assign sel_idx              = hold_q ? hold_idx_q : rr_idx;
   assign repair_req_o         = !any_issued && (hold_q || rr_found);
   assign ack_do               = repair_req_o && repair_ack_i;
   assign cmpl_do              = repair_complete_i && any_issued;
   assign repair_squashed_o    = cmpl_do && squashed_q[iss_idx];
   assign repair_is_store_o    = is_store_q[sel_idx];
   assign repair_req_addr_o    = addr_q[sel_idx];
   assign repair_req_data_o    = is_store_q[sel_idx] ? data_q[sel_idx] : '0;
   assign repair_req_rob_idx_o = is_store_q[sel_idx] ? '0 : rob_q[sel_idx];

   // A store completing this cycle must not be captured as a dependency.
   always_comb begin
      ld_dep = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         ld_dep[i] = !free_v[i] && is_store_q[i] &&
                     (addr_q[i][ADDR_W-1:LINE_OFF_W] == ld_alloc_addr_i[ADDR_W-1:LINE_OFF_W]);
      end
      if (st_do && st_alloc_addr_i[ADDR_W-1:LINE_OFF_W] == ld_alloc_addr_i[ADDR_W-1:LINE_OFF_W])
         ld_dep[st_idx] = 1'b1;
      if (cmpl_do) ld_dep[iss_idx] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i] <= FREE;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
            rob_q[i]   <= '0;
            dep_q[i]   <= '0;
         end
         is_store_q <= '0;
         squashed_q <= '0;
         rr_ptr_q   <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (cmpl_do) dep_q[i][iss_idx] <= 1'b0;
            if (cmpl_do && issued_v[i]) begin
               state_q[i] <= FREE;
            end else if (ack_do && sel_idx == IDX_W'(i)) begin
               state_q[i]    <= ISSUED;
               squashed_q[i] <= flush_i && !is_store_q[i];
            end else if (flush_i && state_q[i] == WAIT && !is_store_q[i]) begin
               state_q[i] <= FREE;
            end else if (flush_i && issued_v[i] && !is_store_q[i]) begin
               squashed_q[i] <= 1'b1;
            end else if (ld_do && ld_idx == IDX_W'(i)) begin
               state_q[i]    <= WAIT;
               is_store_q[i] <= 1'b0;
               squashed_q[i] <= 1'b0;
               addr_q[i]     <= ld_alloc_addr_i;
               data_q[i]     <= '0;
               rob_q[i]      <= ld_alloc_rob_idx_i;
               dep_q[i]      <= ld_dep;
            end else if (st_do && st_idx == IDX_W'(i)) begin
               state_q[i]    <= WAIT;
               is_store_q[i] <= 1'b1;
               squashed_q[i] <= 1'b0;
               addr_q[i]     <= st_alloc_addr_i;
               data_q[i]     <= st_alloc_data_i;
               rob_q[i]      <= '0;
               dep_q[i]      <= '0;
            end
         end
         if (ack_do) rr_ptr_q <= sel_idx + IDX_W'(1);
         hold_q     <= repair_req_o && !repair_ack_i && !(flush_i && !is_store_q[sel_idx]);
         hold_idx_q <= sel_idx;
      end
   end
endmodule

// File: tb/tb_lockup_free_mshr.sv
// Directed bench for lockup_free_mshr: allocation, dependencies, round-robin
// issue, flush squashing and asynchronous reset.
module tb_lockup_free_mshr;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        ld_alloc_en_i = 1'b0;
   logic [31:0] ld_alloc_addr_i = '0;
   logic [4:0]  ld_alloc_rob_idx_i = '0;
   logic        st_alloc_en_i = 1'b0;
   logic [31:0] st_alloc_addr_i = '0;
   logic [31:0] st_alloc_data_i = '0;
   logic        ld_full_o, st_full_o;
   logic [3:0]  count_o;
   logic        repair_req_o;
   logic        repair_ack_i = 1'b0;
   logic [31:0] repair_req_addr_o, repair_req_data_o;
   logic [4:0]  repair_req_rob_idx_o;
   logic        repair_is_store_o;
   logic        repair_complete_i = 1'b0;
   logic        repair_squashed_o;

   int total = 0;
   int bad = 0;

   always #5 clk_i = ~clk_i;

   lockup_free_mshr #(
      .NUM_ENTRIES(8), .ADDR_W(32), .DATA_W(32), .ROB_ENTRIES(32), .ROB_IDX_W(5), .LINE_OFF_W(4)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .ld_alloc_en_i(ld_alloc_en_i), .ld_alloc_addr_i(ld_alloc_addr_i),
      .ld_alloc_rob_idx_i(ld_alloc_rob_idx_i),
      .st_alloc_en_i(st_alloc_en_i), .st_alloc_addr_i(st_alloc_addr_i),
      .st_alloc_data_i(st_alloc_data_i),
      .ld_full_o(ld_full_o), .st_full_o(st_full_o), .count_o(count_o),
      .repair_req_o(repair_req_o), .repair_ack_i(repair_ack_i),
      .repair_req_addr_o(repair_req_addr_o), .repair_req_data_o(repair_req_data_o),
      .repair_req_rob_idx_o(repair_req_rob_idx_o), .repair_is_store_o(repair_is_store_o),
      .repair_complete_i(repair_complete_i), .repair_squashed_o(repair_squashed_o)
   );

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic idle();
      flush_i = 1'b0;
      ld_alloc_en_i = 1'b0;
      st_alloc_en_i = 1'b0;
      repair_ack_i = 1'b0;
      repair_complete_i = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count_o); end
      total++; if (ld_full_o !== 1'b0) begin bad++; $display("FAIL rst_ld_full got=%b exp=0", ld_full_o); end
      total++; if (st_full_o !== 1'b0) begin bad++; $display("FAIL rst_st_full got=%b exp=0", st_full_o); end
      total++; if (repair_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", repair_req_o); end
      total++; if (repair_squashed_o !== 1'b0) begin bad++; $display("FAIL rst_squashed got=%b exp=0", repair_squashed_o); end
      step();
      rst_ni = 1'b1;
      step();
   endtask

   task automatic test_basic_load();
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h1000; ld_alloc_rob_idx_i = 5'd5;
      step(); idle(); #1;
      total++; if (repair_req_o !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", repair_req_o); end
      total++; if (repair_req_addr_o !== 32'h1000) begin bad++; $display("FAIL basic_addr got=%h exp=1000", repair_req_addr_o); end
      total++; if (repair_req_rob_idx_o !== 5'd5) begin bad++; $display("FAIL basic_rob got=%0d exp=5", repair_req_rob_idx_o); end
      total++; if (repair_is_store_o !== 1'b0) begin bad++; $display("FAIL basic_is_store got=%b exp=0", repair_is_store_o); end
      total++; if (count_o !== 4'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count_o); end
      repair_ack_i = 1'b1;
      step(); idle(); #1;
      total++; if (repair_req_o !== 1'b0) begin bad++; $display("FAIL basic_req_after_ack got=%b exp=0", repair_req_o); end
      repair_complete_i = 1'b1; #1;
      total++; if (repair_squashed_o !== 1'b0) begin bad++; $display("FAIL basic_squashed got=%b exp=0", repair_squashed_o); end
      step(); idle(); #1;
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL basic_count_done got=%0d exp=0", count_o); end
      repair_complete_i = 1'b1; #1;
      total++; if (repair_squashed_o !== 1'b0) begin bad++; $display("FAIL spurious_cmpl_squashed got=%b exp=0", repair_squashed_o); end
      step(); idle(); #1;
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL spurious_cmpl_count got=%0d exp=0", count_o); end
   endtask

   task automatic test_dep();
      st_alloc_en_i = 1'b1; st_alloc_addr_i = 32'h2004; st_alloc_data_i = 32'hDEAD_BEEF;
      step(); idle();
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h2008; ld_alloc_rob_idx_i = 5'd7;
      step(); idle(); #1;
      total++; if (count_o !== 4'd2) begin bad++; $display("FAIL dep_count got=%0d exp=2", count_o); end
      total++; if (repair_is_store_o !== 1'b1) begin bad++; $display("FAIL dep_store_first got=%b exp=1", repair_is_store_o); end
      total++; if (repair_req_addr_o !== 32'h2004) begin bad++; $display("FAIL dep_st_addr got=%h exp=2004", repair_req_addr_o); end
      total++; if (repair_req_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dep_st_data got=%h exp=deadbeef", repair_req_data_o); end
      total++; if (repair_req_rob_idx_o !== 5'd0) begin bad++; $display("FAIL dep_st_rob got=%0d exp=0", repair_req_rob_idx_o); end
      repair_ack_i = 1'b1;
      step(); idle();
      repair_complete_i = 1'b1;
      step(); idle(); #1;
      total++; if (repair_req_o !== 1'b1) begin bad++; $display("FAIL dep_ld_req got=%b exp=1", repair_req_o); end
      total++; if (repair_req_addr_o !== 32'h2008) begin bad++; $display("FAIL dep_ld_addr got=%h exp=2008", repair_req_addr_o); end
      total++; if (repair_req_rob_idx_o !== 5'd7) begin bad++; $display("FAIL dep_ld_rob got=%0d exp=7", repair_req_rob_idx_o); end
      total++; if (repair_req_data_o !== 32'h0) begin bad++; $display("FAIL dep_ld_data got=%h exp=0", repair_req_data_o); end
      repair_ack_i = 1'b1;
      step(); idle();
      repair_complete_i = 1'b1;
      step(); idle(); #1;
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL dep_count_done got=%0d exp=0", count_o); end
   endtask

   task automatic test_full();
      int stores_seen = 0;
      for (int i = 0; i < 7; i++) begin
         ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h3000 + 32'(i * 16); ld_alloc_rob_idx_i = 5'(i);
         step(); idle();
      end
      #1;
      total++; if (count_o !== 4'd7) begin bad++; $display("FAIL full_count7 got=%0d exp=7", count_o); end
      total++; if (ld_full_o !== 1'b0) begin bad++; $display("FAIL full_ld_full7 got=%b exp=0", ld_full_o); end
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h3070; ld_alloc_rob_idx_i = 5'd7;
      st_alloc_en_i = 1'b1; st_alloc_addr_i = 32'h3080; st_alloc_data_i = 32'h1;
      #1;
      total++; if (st_full_o !== 1'b1) begin bad++; $display("FAIL contested_st_full got=%b exp=1", st_full_o); end
      total++; if (ld_full_o !== 1'b0) begin bad++; $display("FAIL contested_ld_full got=%b exp=0", ld_full_o); end
      step(); idle(); #1;
      total++; if (count_o !== 4'd8) begin bad++; $display("FAIL full_count8 got=%0d exp=8", count_o); end
      total++; if (ld_full_o !== 1'b1) begin bad++; $display("FAIL full_ld_full got=%b exp=1", ld_full_o); end
      total++; if (st_full_o !== 1'b1) begin bad++; $display("FAIL full_st_full got=%b exp=1", st_full_o); end
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h9000; ld_alloc_rob_idx_i = 5'd9;
      step(); idle(); #1;
      total++; if (count_o !== 4'd8) begin bad++; $display("FAIL full_drop_count got=%0d exp=8", count_o); end
      repair_ack_i = 1'b1;
      step(); idle();
      repair_complete_i = 1'b1;
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h9000; ld_alloc_rob_idx_i = 5'd9;
      #1;
      total++; if (ld_full_o !== 1'b1) begin bad++; $display("FAIL freed_same_cycle_ld_full got=%b exp=1", ld_full_o); end
      step(); idle(); #1;
      total++; if (count_o !== 4'd7) begin bad++; $display("FAIL freed_same_cycle_count got=%0d exp=7", count_o); end
      for (int c = 0; c < 40; c++) begin
         if (count_o == 4'd0) break;
         if (repair_req_o) begin
            if (repair_is_store_o) stores_seen++;
            repair_ack_i = 1'b1;
            step(); idle();
            repair_complete_i = 1'b1;
            step(); idle(); #1;
         end else begin
            step(); #1;
         end
      end
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL full_drain_timeout count got=%0d exp=0", count_o); end
      total++; if (stores_seen != 0) begin bad++; $display("FAIL full_dropped_store_issued got=%0d exp=0", stores_seen); end
   endtask

   task automatic test_flush();
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h4000; ld_alloc_rob_idx_i = 5'd3;
      step(); idle();
      repair_ack_i = 1'b1;
      step(); idle();
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h5000; ld_alloc_rob_idx_i = 5'd4;
      st_alloc_en_i = 1'b1; st_alloc_addr_i = 32'h6000; st_alloc_data_i = 32'h55;
      step(); idle(); #1;
      total++; if (repair_req_o !== 1'b0) begin bad++; $display("FAIL flush_req_while_issued got=%b exp=0", repair_req_o); end
      total++; if (count_o !== 4'd3) begin bad++; $display("FAIL flush_count_pre got=%0d exp=3", count_o); end
      flush_i = 1'b1;
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h7000; ld_alloc_rob_idx_i = 5'd6;
      step(); idle(); #1;
      total++; if (count_o !== 4'd2) begin bad++; $display("FAIL flush_count_post got=%0d exp=2", count_o); end
      repair_complete_i = 1'b1; #1;
      total++; if (repair_squashed_o !== 1'b1) begin bad++; $display("FAIL flush_squashed got=%b exp=1", repair_squashed_o); end
      step(); idle(); #1;
      total++; if (repair_req_o !== 1'b1) begin bad++; $display("FAIL flush_store_req got=%b exp=1", repair_req_o); end
      total++; if (repair_is_store_o !== 1'b1) begin bad++; $display("FAIL flush_store_kind got=%b exp=1", repair_is_store_o); end
      total++; if (repair_req_addr_o !== 32'h6000) begin bad++; $display("FAIL flush_store_addr got=%h exp=6000", repair_req_addr_o); end
      total++; if (repair_req_data_o !== 32'h55) begin bad++; $display("FAIL flush_store_data got=%h exp=55", repair_req_data_o); end
      repair_ack_i = 1'b1;
      step(); idle();
      repair_complete_i = 1'b1; #1;
      total++; if (repair_squashed_o !== 1'b0) begin bad++; $display("FAIL flush_store_squashed got=%b exp=0", repair_squashed_o); end
      step(); idle(); #1;
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL flush_count_done got=%0d exp=0", count_o); end
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h7000; ld_alloc_rob_idx_i = 5'd9;
      step(); idle(); #1;
      total++; if (repair_req_o !== 1'b1) begin bad++; $display("FAIL flush_ack_req got=%b exp=1", repair_req_o); end
      repair_ack_i = 1'b1; flush_i = 1'b1;
      step(); idle(); #1;
      total++; if (count_o !== 4'd1) begin bad++; $display("FAIL flush_ack_count got=%0d exp=1", count_o); end
      total++; if (repair_req_o !== 1'b0) begin bad++; $display("FAIL flush_ack_req_after got=%b exp=0", repair_req_o); end
      repair_complete_i = 1'b1; #1;
      total++; if (repair_squashed_o !== 1'b1) begin bad++; $display("FAIL flush_ack_squashed got=%b exp=1", repair_squashed_o); end
      step(); idle();
   endtask

   task automatic test_rr();
      logic [31:0] la [3];
      logic [4:0]  exp_rob [3];
      logic [4:0]  nr [3];
      logic [31:0] na [3];
      la[0] = 32'hA000; la[1] = 32'hB000; la[2] = 32'hC000;
      nr[0] = 5'd10; nr[1] = 5'd11; nr[2] = 5'd13;
      na[0] = 32'hD000; na[1] = 32'hE000; na[2] = 32'hF000;
      exp_rob[0] = 5'd13; exp_rob[1] = 5'd10; exp_rob[2] = 5'd11;
      rst_ni = 1'b0; step(); rst_ni = 1'b1; step();
      for (int i = 0; i < 3; i++) begin
         ld_alloc_en_i = 1'b1; ld_alloc_addr_i = la[i]; ld_alloc_rob_idx_i = 5'(20 + i);
         step(); idle();
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         total++; if (repair_req_rob_idx_o !== 5'(20 + k)) begin bad++; $display("FAIL rr_first_order k=%0d got=%0d exp=%0d", k, repair_req_rob_idx_o, 20 + k); end
         repair_ack_i = 1'b1;
         step(); idle();
         if (k < 2) begin
            repair_complete_i = 1'b1;
            step(); idle(); #1;
         end
      end
      for (int i = 0; i < 3; i++) begin
         ld_alloc_en_i = 1'b1; ld_alloc_addr_i = na[i]; ld_alloc_rob_idx_i = nr[i];
         step(); idle();
      end
      repair_complete_i = 1'b1;
      step(); idle(); #1;
      for (int k = 0; k < 3; k++) begin
         total++; if (repair_req_o !== 1'b1 || repair_req_rob_idx_o !== exp_rob[k]) begin
            bad++; $display("FAIL rr_wrap_order k=%0d req=%b got=%0d exp=%0d", k, repair_req_o, repair_req_rob_idx_o, exp_rob[k]);
         end
         repair_ack_i = 1'b1;
         step(); idle();
         repair_complete_i = 1'b1;
         step(); idle(); #1;
      end
   endtask

   task automatic test_async_reset();
      ld_alloc_en_i = 1'b1; ld_alloc_addr_i = 32'h1230; ld_alloc_rob_idx_i = 5'd1;
      step(); idle();
      repair_ack_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1;
      total++; if (repair_req_o !== 1'b0) begin bad++; $display("FAIL arst_req got=%b exp=0", repair_req_o); end
      total++; if (count_o !== 4'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", count_o); end
      total++; if (ld_full_o !== 1'b0 || st_full_o !== 1'b0) begin bad++; $display("FAIL arst_full got=%b%b exp=00", ld_full_o, st_full_o); end
      total++; if (repair_squashed_o !== 1'b0) begin bad++; $display("FAIL arst_squashed got=%b exp=0", repair_squashed_o); end
      idle();
      step();
      rst_ni = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_load();
      test_dep();
      test_full();
      test_flush();
      test_rr();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
